uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Next-generation UART receiver: oversampled serial in, 5-8 data bits, optional parity, 1/2 stop bits.
//  Received words, with per-word parity/framing flags, go into a FIFO drained through a valid/ready port.
//  The block drives rts_n from FIFO fill level for hardware flow control.
//  Sits between the baud-tick generator and the bus/register interface of the UART subsystem.
// PARAMETERS
//  OSR         16  oversample ticks per bit; even, >=8
//  FIFO_DEPTH  8   receive FIFO entries; power of 2, >=2
//  RTS_THRESH  6   fill level at or above which rts_n deasserts (1..FIFO_DEPTH)
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous reset, active-low
//  tick          in   1   oversample enable, one clk wide, OSR per bit period
//  rx            in   1   serial input, asynchronous to clk
//  data_bit_num  in   2   00=5, 01=6, 10=7, 11=8 data bits
//  stop_bit_num  in   1   0=1 stop bit, 1=2 stop bits
//  parity_en     in   1   1=parity bit present after data
//  parity_type   in   1   0=even, 1=odd
//  rx_data       out  8   FIFO head data, LSB = first bit received, zero-extended above N bits
//  rx_perr       out  1   FIFO head parity error flag
//  rx_ferr       out  1   FIFO head framing error flag
//  rx_valid      out  1   FIFO non-empty
//  rx_ready      in   1   consumer accepts head; pop when rx_valid & rx_ready
//  fifo_level    out  $clog2(FIFO_DEPTH+1)  current entry count
//  overrun       out  1   sticky; set when a word is dropped
//  ovr_clr       in   1   clears overrun (set wins if same cycle)
//  rts_n         out  1   0 = send allowed; registered: 1 when fifo_level >= RTS_THRESH
//  break_det     out  1   one-clk pulse on line break (0 when macro off)
// BEHAVIOUR
//  Reset: all outputs 0 except rts_n=1; FSM IDLE; FIFO empty. rts_n falls on first clk after reset.
//  rx passes through a 2-flop synchroniser (rxs); all decisions use rxs, only on tick=1.
//  Config inputs latched on IDLE->START; changes mid-frame have no effect on the current frame.
//  FSM (tick_cnt counts ticks, cleared on every state change):
//   IDLE  : rxs=0 -> START.
//   START : at tick_cnt=OSR/2-1 sample; rxs=1 -> IDLE (glitch rejected, nothing pushed), else -> DATA.
//   DATA  : sample at tick_cnt=OSR-1 (bit centre), shift LSB-first; after N bits -> PARITY if parity_en else STOP.
//   PARITY: sample at OSR-1; perr = (XOR(data,p) != parity_type) -> STOP.
//   STOP  : sample at OSR-1; rxs=0 sets ferr; after 1 or 2 stop samples push word, -> IDLE.
//  ferr set if any stop sample is 0; perr=0 when parity_en=0.
//  Push occurs in the clk of the last stop-bit sample; rx_valid rises next clk (latency 1 clk from push).
//  FIFO: show-ahead, head outputs registered-memory read; pointers wrap mod FIFO_DEPTH.
//  Full and push without pop: word dropped, overrun<=1, FIFO unchanged.
//  Full with simultaneous push+pop: both succeed, level unchanged.
//  Empty with rx_ready=1: no pop, level stays 0; rx_data holds last value (don't care).
//  Reset mid-frame: frame discarded, FIFO cleared, FSM IDLE.
// CONFIGURATION
//  UART_RX_BREAK_DET_EN defined: frame with all data bits 0, parity bit (if any) 0 and ferr=1
//   is a break: not pushed, break_det pulses 1 clk, FSM holds in BRK until a tick with rxs=1, then IDLE.
//  Undefined: no BRK state; break_det tied 0; such a frame is pushed as data 0x00 with ferr=1,
//   and FSM returns to IDLE (a held-low line yields repeated 0x00/ferr words).
// TESTING
//  8N1, send 0xA5, rx_ready=1 -> rx_data=0xA5, perr=0, ferr=0, single pop, level back to 0.
//  7E2 even parity, send 0x35 with wrong parity bit -> rx_data=0x35, rx_perr=1, ferr=0.
//  5N1, stop bit driven 0, byte 0x1F -> rx_data=0x1F, rx_ferr=1.
//  rx_ready=0, send FIFO_DEPTH+1 bytes -> level=8, rts_n=1 from level 6, 9th byte dropped,
//   overrun=1 until ovr_clr; then drain -> bytes 1..8 in order.
//  rx low pulse of OSR/4 ticks -> FSM back to IDLE, nothing pushed, rx_valid stays 0.
//  Line held low 3 frame times: with UART_RX_BREAK_DET_EN one break_det pulse, level=0;
//   without it repeated 0x00 words with ferr=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a flagged receive FIFO with RTS flow control.
// Line-break detection is compiled in when UART_RX_BREAK_DET_EN is defined.
module uart_rx_fifo #(
  parameter int unsigned OSR        = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RTS_THRESH = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick,
  input  logic                            rx,
  input  logic [1:0]                      data_bit_num,
  input  logic                            stop_bit_num,
  input  logic                            parity_en,
  input  logic                            parity_type,
  output logic [7:0]                      rx_data,
  output logic                            rx_perr,
  output logic                            rx_ferr,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overrun,
  input  logic                            ovr_clr,
  output logic                            rts_n,
  output logic                            break_det
);

  localparam int unsigned CntW = $clog2(OSR);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(OSR / 2 - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(OSR - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
`ifdef UART_RX_BREAK_DET_EN
    , StBrk
`endif
  } state_e;

  // Two-flop synchroniser; resets to the idle (mark) level so reset never looks like a start bit.
  logic rx_meta_q, rxs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic [1:0]      cfg_dbits_q, cfg_dbits_d;
  logic            cfg_stop_q, cfg_stop_d;
  logic            cfg_pen_q, cfg_pen_d;
  logic            cfg_ptype_q, cfg_ptype_d;
  logic            stop_ferr;
  logic            push;
  logic [9:0]      push_word;

  assign stop_ferr = ferr_q | ~rxs_q;
  assign push_word = {perr_q, stop_ferr, data_q};

`ifdef UART_RX_BREAK_DET_EN
  logic par_bit_q, par_bit_d;
  logic brk_hit;
  logic break_det_q;
`endif

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    cfg_dbits_d = cfg_dbits_q;
    cfg_stop_d  = cfg_stop_q;
    cfg_pen_d   = cfg_pen_q;
    cfg_ptype_d = cfg_ptype_q;
    push        = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    par_bit_d   = par_bit_q;
    brk_hit     = 1'b0;
`endif
    if (tick) begin
      tick_cnt_d = tick_cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          tick_cnt_d = '0;
          if (!rxs_q) begin
            state_d     = StStart;
            cfg_dbits_d = data_bit_num;
            cfg_stop_d  = stop_bit_num;
            cfg_pen_d   = parity_en;
            cfg_ptype_d = parity_type;
            data_d      = '0;
            perr_d      = 1'b0;
            ferr_d      = 1'b0;
            bit_cnt_d   = '0;
            stop_cnt_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_d   = 1'b0;
`endif
          end
        end
        StStart: begin
          if (tick_cnt_q == HalfCnt) begin
            tick_cnt_d = '0;
            state_d    = rxs_q ? StIdle : StData;
          end
        end
        StData: begin
          if (tick_cnt_q == LastCnt) begin
            tick_cnt_d        = '0;
            data_d[bit_cnt_q] = rxs_q;
            bit_cnt_d         = bit_cnt_q + 3'd1;
            // {1, dbits} is the index of the last data bit (4..7).
            if (bit_cnt_q == {1'b1, cfg_dbits_q}) begin
              state_d = cfg_pen_q ? StParity : StStop;
            end
          end
        end
        StParity: begin
          if (tick_cnt_q == LastCnt) begin
            tick_cnt_d = '0;
            perr_d     = ((^data_q) ^ rxs_q) != cfg_ptype_q;
            state_d    = StStop;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_d  = rxs_q;
`endif
          end
        end
        StStop: begin
          if (tick_cnt_q == LastCnt) begin
            tick_cnt_d = '0;
            ferr_d     = stop_ferr;
            if (stop_cnt_q == cfg_stop_q) begin
              state_d = StIdle;
`ifdef UART_RX_BREAK_DET_EN
              if ((data_q == 8'h00) && !par_bit_q && stop_ferr) begin
                brk_hit = 1'b1;
                state_d = StBrk;
              end else begin
                push = 1'b1;
              end
`else
              push = 1'b1;
`endif
            end else begin
              stop_cnt_d = 1'b1;
            end
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        StBrk: begin
          tick_cnt_d = '0;
          if (rxs_q) state_d = StIdle;
        end
`endif
        default: begin
          tick_cnt_d = '0;
          state_d    = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      cfg_dbits_q <= '0;
      cfg_stop_q  <= 1'b0;
      cfg_pen_q   <= 1'b0;
      cfg_ptype_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      cfg_dbits_q <= cfg_dbits_d;
      cfg_stop_q  <= cfg_stop_d;
      cfg_pen_q   <= cfg_pen_d;
      cfg_ptype_q <= cfg_ptype_d;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit_q   <= 1'b0;
      break_det_q <= 1'b0;
    end else begin
      par_bit_q   <= par_bit_d;
      break_det_q <= brk_hit;
    end
  end

  assign break_det = break_det_q;
`else
  assign break_det = 1'b0;
`endif

  // Receive FIFO: show-ahead, head is read straight out of the storage flops.
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            full, pop, wr_en, ovr_set;
  logic            overrun_q, rts_n_q;

  assign full    = (level_q == LvlW'(FIFO_DEPTH));
  assign pop     = rx_valid & rx_ready;
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      rts_n_q   <= 1'b1;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (ovr_clr) begin
        overrun_q <= 1'b0;
      end
      rts_n_q <= (level_q >= LvlW'(RTS_THRESH));
    end
  end

  assign rx_data    = mem_q[rd_ptr_q][7:0];
  assign rx_ferr    = mem_q[rd_ptr_q][8];
  assign rx_perr    = mem_q[rd_ptr_q][9];
  assign rx_valid   = (level_q != '0);
  assign fifo_level = level_q;
  assign overrun    = overrun_q;
  assign rts_n      = rts_n_q;

endmodule
